gp_reg_file: RTL and testbench
==============================

GP_REG_FILE -- requirements
Module: gp_reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32: number of registers, legal range 2..64.
REQ-003 The block SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have derived parameter ADDR_W = ceil(log2(DEPTH)): address width.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 WR_EN  input  1  write request, sampled on rising CLK.
REQ-008 WR_ADDR  input  ADDR_W  write register index.
REQ-009 WR_DATA  input  WIDTH  write data.
REQ-010 RD_ADDR_A  input  ADDR_W  read port A index.
REQ-011 RD_DATA_A  output  WIDTH  read port A data.
REQ-012 RD_ADDR_B  input  ADDR_W  read port B index.
REQ-013 RD_DATA_B  output  WIDTH  read port B data.
REQ-014 The block SHALL use one clock, CLK; its reset SHALL be RST_N, asynchronous and active-low.

Function
REQ-015 Storage SHALL be DEPTH x WIDTH edge-triggered registers; no level-sensitive latches.
REQ-016 A write SHALL occur on a rising CLK edge when RST_N=1 and WR_EN=1; storage SHALL update one edge after the request, with latency 1.
REQ-017 Both read ports SHALL be combinational from storage, with zero-cycle latency, and independent of each other and of WR_EN.
REQ-018 With ZERO_REG=1, writes to index 0 SHALL be discarded, and reads of index 0 SHALL return 0 on both ports, regardless of any bypass.
REQ-019 A write with WR_ADDR >= DEPTH (non-power-of-2 DEPTH) SHALL be ignored; a read with an address >= DEPTH SHALL return 0.
REQ-020 Both ports SHALL be able to read the same index simultaneously and SHALL return identical data.
REQ-021 A read of an index being written in the same cycle SHALL follow REQ-027/REQ-028.
REQ-022 WR_EN=0 SHALL leave all storage unchanged; X on WR_ADDR/WR_DATA while WR_EN=0 SHALL have no effect.

Reset
REQ-023 RST_N=0 SHALL clear every register to 0 immediately, without waiting for CLK; RD_DATA_A and RD_DATA_B SHALL therefore read 0 for every index.
REQ-024 Writes SHALL be blocked while RST_N=0, including a CLK edge coincident with assertion.
REQ-025 Reset asserted mid-operation SHALL discard any pending write; the first write accepted after reset SHALL be at the first rising CLK edge with RST_N=1.

Configuration
REQ-026 The block SHALL have macro GP_REG_FILE_BYPASS_EN, which selects write-to-read forwarding.
REQ-027 With GP_REG_FILE_BYPASS_EN defined: when WR_EN=1, RST_N=1 and RD_ADDR_x==WR_ADDR (valid, non-zero-reg), RD_DATA_x SHALL equal WR_DATA in the same cycle.
REQ-028 Without GP_REG_FILE_BYPASS_EN: a read of the index being written SHALL return the old stored value until after the edge.

Verification
REQ-029 Reset, then read all indices on A and B -> all 0; pulse RST_N low mid-run after writes -> all 0 immediately, without CLK.
REQ-030 Write 0xDEADBEEF to reg 5; read A=5, B=5 -> both 0xDEADBEEF after the edge; the cycle before the edge, both ports return 0.
REQ-031 ZERO_REG=1: write 0x12345678 to reg 0 -> read returns 0; ZERO_REG=0 -> read returns 0x12345678.
REQ-032 Same-cycle write 0xA5A5A5A5 to reg 7 while reading 7 (old 0x11111111) -> bypass build: 0xA5A5A5A5; non-bypass build: 0x11111111, then 0xA5A5A5A5 after the edge.
REQ-033 DEPTH=24: write 0xFFFF to index 30 -> ignored, read index 30 -> 0, regs 0..23 unchanged.
REQ-034 Back-to-back writes regs 1..DEPTH-1 with data = index*3, then randomised dual-port reads -> match scoreboard; WR_EN=0 with X data -> no change.

Source files
------------

// File: rtl/gp_reg_file.sv
// Parameterised general-purpose register file: one synchronous write port and two combinational read ports.
// Define GP_REG_FILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module gp_reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_accept;

    // Non-power-of-2 depths leave a hole in the address space that must read as zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign wr_accept = wr_en && rst_n && addr_ok(wr_addr) && !is_zero_reg(wr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Register 0 is never written when hardwired, so storage alone keeps it reading zero.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr_ok(addr)) begin
            val = mem[addr];
        end
`ifdef GP_REG_FILE_BYPASS_EN
        if (wr_accept && (addr == wr_addr)) begin
            val = wr_data;
        end
`endif
        return val;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
    end

    always_comb begin
        rd_data_b = read_port(rd_addr_b);
    end

endmodule

// File: tb/tb_gp_reg_file.sv
// Self-checking bench for gp_reg_file: a default instance (32 regs, zero reg) and a DEPTH=24, ZERO_REG=0 instance.
// Both share stimulus and are checked against array models kept here.
module tb_gp_reg_file;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a0, rd_data_b0;
    logic [31:0] rd_data_a1, rd_data_b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model0 [32];
    logic [31:0] model1 [24];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a0;
        logic [31:0] exp_b0;
        logic [31:0] exp_a1;
        logic [31:0] exp_b1;
    } vec_t;

    vec_t vecs [6];

    gp_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a0),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b0)
    );

    gp_reg_file #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a1),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected read value from the register-file rules applied to the model arrays.
    function automatic logic [31:0] exp_rd(input int which, input logic [4:0] addr);
        int depth;
        depth = (which == 0) ? 32 : 24;
        if (!rst_n) return 32'h0;
        if (int'(addr) >= depth) return 32'h0;
        if (which == 0 && addr == 5'd0) return 32'h0;
`ifdef GP_REG_FILE_BYPASS_EN
        if (wr_en === 1'b1 && wr_addr === addr) return wr_data;
`endif
        return (which == 0) ? model0[addr] : model1[addr];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) model0[i] = 32'h0;
        for (int i = 0; i < 24; i++) model1[i] = 32'h0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic check_ports(input string name);
        checkOutput({name, " dut0.a"}, rd_data_a0, exp_rd(0, rd_addr_a));
        checkOutput({name, " dut0.b"}, rd_data_b0, exp_rd(0, rd_addr_b));
        checkOutput({name, " dut1.a"}, rd_data_a1, exp_rd(1, rd_addr_a));
        checkOutput({name, " dut1.b"}, rd_data_b1, exp_rd(1, rd_addr_b));
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        #1;
    endtask

    // Advance one rising edge and apply the accepted write to the models.
    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            if (wr_addr != 5'd0) model0[wr_addr] = wr_data;
            if (int'(wr_addr) < 24) model1[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check_ports(name);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        clear_models();

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd30, 32'h0000FFFF, 5'd30, 5'd5,  32'h0000FFFF, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd23, 32'h11111111, 32'h00000000, 32'h11111111, 32'h00000000};
        vecs[4] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd7,  32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 32'h11111111};
        vecs[5] = '{1'b1, 5'd23, 32'hCAFEF00D, 5'd23, 5'd31, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'h00000000};

        #3;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(i);
            #1;
            checkOutput("reset dut0.a", rd_data_a0, 32'h0);
            checkOutput("reset dut0.b", rd_data_b0, 32'h0);
            checkOutput("reset dut1.a", rd_data_a1, 32'h0);
            checkOutput("reset dut1.b", rd_data_b1, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Value must not be visible on either port until the edge (unless forwarded).
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
`ifdef GP_REG_FILE_BYPASS_EN
        checkOutput("pre-edge r5 a", rd_data_a0, 32'hDEADBEEF);
        checkOutput("pre-edge r5 b", rd_data_b0, 32'hDEADBEEF);
`else
        checkOutput("pre-edge r5 a", rd_data_a0, 32'h0);
        checkOutput("pre-edge r5 b", rd_data_b0, 32'h0);
`endif

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb);
            tick();
            checkOutput($sformatf("vec%0d dut0.a", v), rd_data_a0, vecs[v].exp_a0);
            checkOutput($sformatf("vec%0d dut0.b", v), rd_data_b0, vecs[v].exp_b0);
            checkOutput($sformatf("vec%0d dut1.a", v), rd_data_a1, vecs[v].exp_a1);
            checkOutput($sformatf("vec%0d dut1.b", v), rd_data_b1, vecs[v].exp_b1);
        end

        // Same-cycle write and read of reg 7 holding 0x11111111.
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
`ifdef GP_REG_FILE_BYPASS_EN
        checkOutput("same-cycle r7 a", rd_data_a0, 32'hA5A5A5A5);
        checkOutput("same-cycle r7 b", rd_data_b0, 32'hA5A5A5A5);
`else
        checkOutput("same-cycle r7 a", rd_data_a0, 32'h11111111);
        checkOutput("same-cycle r7 b", rd_data_b0, 32'h11111111);
`endif
        tick();
        checkOutput("after-edge r7 a", rd_data_a0, 32'hA5A5A5A5);
        checkOutput("after-edge r7 b", rd_data_b1, 32'hA5A5A5A5);

        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i * 3), 5'(i), 5'(i - 1));
            check_ports($sformatf("fill%0d pre", i));
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check_all("fill readback");

        wr_en   = 1'b0;
        wr_addr = 'x;
        wr_data = 'x;
        tick();
        tick();
        check_all("idle x");

        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            check_ports($sformatf("rand%0d", n));
            tick();
            check_ports($sformatf("rand%0d post", n));
        end

        // Asynchronous reset between edges must clear everything at once.
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        clear_models();
        #1;
        check_ports("async reset");
        check_all("async reset all");

        applyStimulus(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9);
        tick();
        checkOutput("write in reset dut0", rd_data_a0, 32'h0);
        checkOutput("write in reset dut1", rd_data_b1, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ports("post-reset pre-edge");
        tick();
        checkOutput("first write dut0", rd_data_a0, 32'h0BADF00D);
        checkOutput("first write dut1", rd_data_b1, 32'h0BADF00D);
        check_ports("first write model");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
